// File: rtl/reg_wb_arbiter.sv
// Two-requester (ALU, load) writeback arbiter for the register file write port; grants are combinational, the write stage is registered.
// Optional build macro WB_RR_ARB_EN swaps the starvation-boost priority FSM for strict round robin.
module reg_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_req,
  input  logic [ADDR_W-1:0]    alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_gnt,
  input  logic                 mem_req,
  input  logic [ADDR_W-1:0]    mem_reg,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_gnt,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    Write_Reg,
  output logic [DATA_W-1:0]    Write_Bus,
  output logic [2**ADDR_W-1:0] pend_mask
);

  typedef enum logic {MEM_PRI, ALU_PRI} state_t;

  state_t              state_q, state_d;
  logic                reg_write_q;
  logic [ADDR_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]   write_bus_q;

  // Grants are gated by rst_n so nothing is accepted while the write stage is held in reset.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == MEM_PRI) begin
        mem_gnt = mem_req;
        alu_gnt = alu_req & ~mem_req;
      end else begin
        alu_gnt = alu_req;
        mem_gnt = mem_req & ~alu_req;
      end
    end
  end

`ifdef WB_RR_ARB_EN
  always_comb begin
    state_d = state_q;
    if (mem_gnt)      state_d = ALU_PRI;
    else if (alu_gnt) state_d = MEM_PRI;
  end
`else
  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!alu_req || alu_gnt)    wait_cnt_d = '0;
    else if (wait_cnt_q != 4'hF) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // The boost looks at the registered count, so ALU loses once more in the cycle the switch is decided.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_PRI: if (wait_cnt_q >= MaxWaitC && !alu_gnt) state_d = ALU_PRI;
      ALU_PRI: if (alu_gnt) state_d = MEM_PRI;
      default: state_d = MEM_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MEM_PRI;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      write_bus_q <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= alu_gnt | mem_gnt;
      if (alu_gnt) begin
        write_reg_q <= alu_reg;
        write_bus_q <= alu_data;
      end else if (mem_gnt) begin
        write_reg_q <= mem_reg;
        write_bus_q <= mem_data;
      end
    end
  end

  assign RegWrite  = reg_write_q;
  assign Write_Reg = write_reg_q;
  assign Write_Bus = write_bus_q;

  always_comb begin
    pend_mask = '0;
    if (alu_req && !alu_gnt) pend_mask[alu_reg]     = 1'b1;
    if (mem_req && !mem_gnt) pend_mask[mem_reg]     = 1'b1;
    if (reg_write_q)         pend_mask[write_reg_q] = 1'b1;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: per-scenario tasks plus a write scoreboard.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_req, mem_req;
  logic [3:0]  alu_reg, mem_reg;
  logic [15:0] alu_data, mem_data;
  logic        alu_gnt, mem_gnt;
  logic        RegWrite;
  logic [3:0]  Write_Reg;
  logic [15:0] Write_Bus;
  logic [15:0] pend_mask;

  int checks = 0;
  int errors = 0;
  logic [19:0] sb_q[$];
  logic [19:0] sb_exp;
  logic        prev_a = 1'b0, prev_m = 1'b0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_req(alu_req), .alu_reg(alu_reg), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_reg(mem_reg), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Bus(Write_Bus), .pend_mask(pend_mask)
  );

  // Scoreboard: every registered write must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (rst_n && RegWrite) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: write reg=%0d data=%h, required no write", Write_Reg, Write_Bus);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({Write_Reg, Write_Bus} !== sb_exp) begin
          errors++;
          $display("FAIL sb_write: got reg=%0d data=%h, required reg=%0d data=%h",
                   Write_Reg, Write_Bus, sb_exp[19:16], sb_exp[15:0]);
        end
      end
    end
  end

  // Requesters must hold req until granted.
  always @(posedge clk) begin
    if (rst_n && ((prev_a && !alu_req) || (prev_m && !mem_req))) begin
      errors++;
      $display("FAIL proto_req_drop: alu_req=%b mem_req=%b dropped before grant", alu_req, mem_req);
    end
    prev_a <= rst_n & alu_req & ~alu_gnt;
    prev_m <= rst_n & mem_req & ~mem_gnt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_drain: %0d writes outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_req = 0; mem_req = 0; alu_reg = 0; mem_reg = 0; alu_data = 0; mem_data = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (RegWrite !== 1'b0)   begin errors++; $display("FAIL rst_regwrite: got %b, required 0", RegWrite); end
    checks++; if (Write_Reg !== 4'd0)  begin errors++; $display("FAIL rst_write_reg: got %0d, required 0", Write_Reg); end
    checks++; if (Write_Bus !== 16'd0) begin errors++; $display("FAIL rst_write_bus: got %h, required 0000", Write_Bus); end
    alu_req = 1; alu_reg = 3; mem_req = 1; mem_reg = 5;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got alu=%b mem=%b, required 0 0", alu_gnt, mem_gnt); end
    checks++; if (pend_mask !== 16'h0028) begin errors++; $display("FAIL rst_pend: got %h, required 0028", pend_mask); end
    tick(); alu_req = 0; mem_req = 0;
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_single_alu();
    tick(); alu_req = 1; alu_reg = 3; alu_data = 16'hBEEF;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b10) begin errors++; $display("FAIL single_gnt: got alu=%b mem=%b, required 1 0", alu_gnt, mem_gnt); end
    sb_q.push_back({4'd3, 16'hBEEF});
    tick(); alu_req = 0;
    checks++; if ({RegWrite, Write_Reg, Write_Bus} !== {1'b1, 4'd3, 16'hBEEF}) begin
      errors++; $display("FAIL single_write: got we=%b reg=%0d data=%h, required 1 3 beef", RegWrite, Write_Reg, Write_Bus);
    end
    tick();
    checks++; if ({RegWrite, Write_Reg, Write_Bus} !== {1'b0, 4'd3, 16'hBEEF}) begin
      errors++; $display("FAIL single_hold: got we=%b reg=%0d data=%h, required 0 3 beef", RegWrite, Write_Reg, Write_Bus);
    end
    tick(); test_sb_empty("single");
  endtask

  task automatic test_collision();
    tick(); mem_req = 1; mem_reg = 5; mem_data = 16'h1111; alu_req = 1; alu_reg = 6; alu_data = 16'h2222;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b01) begin errors++; $display("FAIL coll_n: got alu=%b mem=%b, required 0 1", alu_gnt, mem_gnt); end
    sb_q.push_back({4'd5, 16'h1111});
    tick(); mem_req = 0;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b10) begin errors++; $display("FAIL coll_n1: got alu=%b mem=%b, required 1 0", alu_gnt, mem_gnt); end
    sb_q.push_back({4'd6, 16'h2222});
    tick(); alu_req = 0;
    tick(); tick(); test_sb_empty("coll");
  endtask

  task automatic test_same_reg();
    tick(); mem_req = 1; mem_reg = 9; mem_data = 16'hAAAA; alu_req = 1; alu_reg = 9; alu_data = 16'h5555;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b01) begin errors++; $display("FAIL same_first: got alu=%b mem=%b, required 0 1", alu_gnt, mem_gnt); end
    sb_q.push_back({4'd9, 16'hAAAA});
    tick(); mem_req = 0;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b10) begin errors++; $display("FAIL same_second: got alu=%b mem=%b, required 1 0", alu_gnt, mem_gnt); end
    sb_q.push_back({4'd9, 16'h5555});
    tick(); alu_req = 0;
    tick();
    checks++; if ({Write_Reg, Write_Bus} !== {4'd9, 16'h5555}) begin
      errors++; $display("FAIL same_final: got reg=%0d data=%h, required 9 5555", Write_Reg, Write_Bus);
    end
    tick(); test_sb_empty("same");
  endtask

  task automatic test_hazard();
    tick(); mem_req = 1; mem_reg = 7; mem_data = 16'h7001;
    #1;
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL haz_pre_gnt: got mem=%b, required 1", mem_gnt); end
    sb_q.push_back({4'd7, 16'h7001});
    tick(); mem_data = 16'h7002; alu_req = 1; alu_reg = 2; alu_data = 16'h2222;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b01) begin errors++; $display("FAIL haz_gnt0: got alu=%b mem=%b, required 0 1", alu_gnt, mem_gnt); end
    checks++; if (pend_mask !== 16'h0084) begin errors++; $display("FAIL haz_pend0: got %h, required 0084", pend_mask); end
    sb_q.push_back({4'd7, 16'h7002});
    tick(); mem_data = 16'h7003;
    #1;
    checks++; if (pend_mask !== 16'h0084) begin errors++; $display("FAIL haz_pend1: got %h, required 0084", pend_mask); end
    sb_q.push_back({4'd7, 16'h7003});
    tick(); mem_req = 0;
    #1;
    checks++; if ({alu_gnt, pend_mask} !== {1'b1, 16'h0080}) begin
      errors++; $display("FAIL haz_pend2: got alu_gnt=%b mask=%h, required 1 0080", alu_gnt, pend_mask);
    end
    sb_q.push_back({4'd2, 16'h2222});
    tick(); alu_req = 0;
    #1;
    checks++; if (pend_mask !== 16'h0004) begin errors++; $display("FAIL haz_pend3: got %h, required 0004", pend_mask); end
    tick(); tick(); test_sb_empty("haz");
  endtask

  task automatic test_starvation();
    bit exp_a;
    tick(); mem_req = 1; mem_reg = 1; mem_data = 16'h1000; alu_req = 1; alu_reg = 4; alu_data = 16'h4444;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_a = (i == 5) || (i == 7);
      checks++;
      if ({alu_gnt, mem_gnt} !== {exp_a, !exp_a}) begin
        errors++; $display("FAIL starve_gnt[%0d]: got alu=%b mem=%b, required alu=%b mem=%b", i, alu_gnt, mem_gnt, exp_a, !exp_a);
      end
      if (exp_a) sb_q.push_back({alu_reg, alu_data});
      else       sb_q.push_back({mem_reg, mem_data});
      tick();
      if (!exp_a) begin
        mem_data = mem_data + 16'd1;
        if (i == 6) mem_req = 0;
      end else if (i == 5) begin
        alu_data = 16'h5555;
      end else begin
        alu_req = 0;
      end
    end
    tick(); tick(); test_sb_empty("starve");
  endtask

  task automatic test_rr();
    bit exp_m;
    tick(); mem_req = 1; mem_reg = 2; mem_data = 16'hB000; alu_req = 1; alu_reg = 1; alu_data = 16'hA000;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_m = (i % 2) == 0;
      checks++;
      if ({alu_gnt, mem_gnt} !== {!exp_m, exp_m}) begin
        errors++; $display("FAIL rr_gnt[%0d]: got alu=%b mem=%b, required alu=%b mem=%b", i, alu_gnt, mem_gnt, !exp_m, exp_m);
      end
      if (exp_m) sb_q.push_back({mem_reg, mem_data});
      else       sb_q.push_back({alu_reg, alu_data});
      tick();
      if (exp_m) mem_data = mem_data + 16'd1;
      else       alu_data = alu_data + 16'd1;
    end
    alu_req = 0; mem_req = 0;
    tick(); tick(); test_sb_empty("rr");
  endtask

  task automatic test_reset_mid();
    tick(); alu_req = 1; alu_reg = 4'hA; alu_data = 16'hCAFE;
    #1;
    checks++; if (alu_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got alu=%b, required 1", alu_gnt); end
    sb_q.push_back({4'hA, 16'hCAFE});
    tick(); alu_reg = 4'hC; alu_data = 16'h3333; mem_req = 1; mem_reg = 4'hB; mem_data = 16'h7777;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL rmid_inflight: got %b, required 1", RegWrite); end
    #2; rst_n = 1'b0;
    #1;
    checks++; if ({RegWrite, Write_Reg, Write_Bus} !== 21'd0) begin
      errors++; $display("FAIL rmid_async: got we=%b reg=%0d data=%h, required 0 0 0000", RegWrite, Write_Reg, Write_Bus);
    end
    checks++; if ({alu_gnt, mem_gnt} !== 2'b00) begin errors++; $display("FAIL rmid_gnt_rst: got alu=%b mem=%b, required 0 0", alu_gnt, mem_gnt); end
    tick(); tick(); rst_n = 1'b1;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b01) begin errors++; $display("FAIL rmid_rearb0: got alu=%b mem=%b, required 0 1", alu_gnt, mem_gnt); end
    sb_q.push_back({4'hB, 16'h7777});
    tick(); mem_req = 0;
    #1;
    checks++; if ({alu_gnt, mem_gnt} !== 2'b10) begin errors++; $display("FAIL rmid_rearb1: got alu=%b mem=%b, required 1 0", alu_gnt, mem_gnt); end
    sb_q.push_back({4'hC, 16'h3333});
    tick(); alu_req = 0;
    tick(); tick(); test_sb_empty("rmid");
  endtask

  initial begin
    test_reset();
`ifdef WB_RR_ARB_EN
    test_rr();
`endif
    test_single_alu();
    test_collision();
    test_same_reg();
`ifndef WB_RR_ARB_EN
    test_hazard();
    test_starvation();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
